// File: rtl/bnn_ctrl_pkg.sv
// Shared types and default dimensions for the binarized-layer control path.
package bnn_ctrl_pkg;

  localparam int unsigned IN_DIM    = 16;
  localparam int unsigned OUT_DIM   = 8;
  localparam int unsigned BIT_CNT   = 4;
  localparam int unsigned MAX_TILES = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    LATCH = 3'd3,
    EVAL  = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/bnn_layer_sequencer.sv
// Walks one binarized layer tile by tile: loads the input vector once, fetches
// each tile's weights, latches the external datapath result and hands it out.
module bnn_layer_sequencer #(
  parameter int unsigned IN_DIM    = bnn_ctrl_pkg::IN_DIM,
  parameter int unsigned OUT_DIM   = bnn_ctrl_pkg::OUT_DIM,
  parameter int unsigned BIT_CNT   = bnn_ctrl_pkg::BIT_CNT,
  parameter int unsigned MAX_TILES = bnn_ctrl_pkg::MAX_TILES,
  localparam int unsigned TW = $clog2(MAX_TILES),
  localparam int unsigned CW = TW + 1,
  localparam int unsigned IW = IN_DIM * BIT_CNT,
  localparam int unsigned WW = OUT_DIM * IN_DIM,
  localparam int unsigned OW = OUT_DIM * BIT_CNT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_tiles,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  output logic          w_rd_en,
  output logic [TW-1:0] w_addr,
  input  logic [WW-1:0] w_rdata,
  output logic [IW-1:0] dp_value_in,
  output logic [WW-1:0] dp_weight,
  input  logic [OW-1:0] dp_value_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [TW-1:0] out_tile
);

  import bnn_ctrl_pkg::*;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tile_q, tile_d;

  logic          busy_d, done_d, in_ready_d, w_rd_en_d, out_valid_d;
  logic [TW-1:0] w_addr_d, out_tile_d;
  logic [IW-1:0] dp_value_in_d;
  logic [WW-1:0] dp_weight_d;
  logic [OW-1:0] out_data_d;

  // Next state plus next value of every registered output.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tile_d        = tile_q;
    w_addr_d      = w_addr;
    dp_value_in_d = dp_value_in;
    dp_weight_d   = dp_weight;
    out_data_d    = out_data;
    out_tile_d    = out_tile;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d    = (num_tiles > CW'(MAX_TILES)) ? CW'(MAX_TILES) : num_tiles;
          tile_d   = '0;
          w_addr_d = '0;
          state_d  = (num_tiles == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          dp_value_in_d = in_data;
          state_d       = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        dp_weight_d = w_rdata;
        state_d     = EVAL;
      end
      EVAL: begin
        out_data_d = dp_value_out;
        out_tile_d = tile_q;
        state_d    = EMIT;
      end
      EMIT: begin
        // Stop at count-1 so the counter never wraps past the layer.
        if (out_valid && out_ready) begin
          if ({1'b0, tile_q} < (cnt_q - CW'(1))) begin
            tile_d  = tile_q + TW'(1);
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    in_ready_d  = (state_d == LOAD);
    w_rd_en_d   = (state_d == FETCH);
    out_valid_d = (state_d == EMIT);
    if (state_d == FETCH) w_addr_d = tile_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tile_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_ready    <= 1'b0;
      w_rd_en     <= 1'b0;
      w_addr      <= '0;
      dp_value_in <= '0;
      dp_weight   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tile    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tile_q      <= tile_d;
      busy        <= busy_d;
      done        <= done_d;
      in_ready    <= in_ready_d;
      w_rd_en     <= w_rd_en_d;
      w_addr      <= w_addr_d;
      dp_value_in <= dp_value_in_d;
      dp_weight   <= dp_weight_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      out_tile    <= out_tile_d;
    end
  end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Self-checking bench: table of layers plus hand-written reset/zero-tile cases,
// with a weight memory and datapath model around the sequencer.
module tb_bnn_layer_sequencer;
  import bnn_ctrl_pkg::*;

  localparam int unsigned TW = $clog2(MAX_TILES);
  localparam int unsigned IW = IN_DIM * BIT_CNT;
  localparam int unsigned WW = OUT_DIM * IN_DIM;
  localparam int unsigned OW = OUT_DIM * BIT_CNT;
  localparam int          BIG = 1 << 30;

  typedef struct {
    logic [TW:0]   num;
    logic [IW-1:0] x;
    int            exp_cnt;
    int            exp_acc;
    int            stall_tile;
    int            stall_cyc;
    bit            bp;
    bit            spacing;
  } vec_t;

  typedef struct {
    logic [TW-1:0] tile;
    logic [OW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [TW:0]   num_tiles;
  logic          busy, done;
  logic          in_valid, in_ready;
  logic [IW-1:0] in_data;
  logic          w_rd_en;
  logic [TW-1:0] w_addr;
  logic [WW-1:0] w_rdata = '0;
  logic [IW-1:0] dp_value_in;
  logic [WW-1:0] dp_weight;
  logic [OW-1:0] dp_value_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic [TW-1:0] out_tile;

  int checks = 0, errors = 0;
  int cyc = 0, outs = 0, dones = 0, accepts = 0, exp_addr = 0;
  int fetch_cyc = 0, rises = 0, last_rise = 0, dpin_from = BIG;
  int stall_tile = -1, stall_left = 0;
  bit rand_bp = 0, check_spacing = 0, pend = 0, ov_prev = 0;
  logic [IW-1:0] cur_x = '0;
  logic [OW-1:0] held_data = '0;
  logic [TW-1:0] held_tile = '0;
  exp_t sb[$];
  vec_t vecs[7];

  bnn_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .dp_value_in(dp_value_in), .dp_weight(dp_weight), .dp_value_out(dp_value_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tile(out_tile)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] wfn(input logic [TW-1:0] a);
    logic [31:0] k;
    k = (32'(a) + 32'd1) * 32'h9E37_79B9;
    return {32'hDEAD_0000 | 32'(a), ~k, 32'h0F0F_0F0F ^ k, k};
  endfunction

  function automatic logic [OW-1:0] exp_out(input logic [TW-1:0] t, input logic [IW-1:0] x);
    logic [WW-1:0] w;
    w = wfn(t);
    return w[OW-1:0] ^ x[OW-1:0] ^ x[IW-1:OW];
  endfunction

  // Weight memory with one-cycle read latency and a simple combinational datapath.
  always @(posedge clk) if (w_rd_en) w_rdata <= wfn(w_addr);
  assign dp_value_out = dp_weight[OW-1:0] ^ dp_value_in[OW-1:0] ^ dp_value_in[IW-1:OW];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result consumer: scripted stall on one tile, optional random backpressure.
  always @(posedge clk) begin
    #1;
    if (out_valid && stall_left > 0 && int'(out_tile) == stall_tile) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
  end

  // Protocol monitor and scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) dones++;
      if (in_valid && in_ready) begin
        accepts++;
        dpin_from = cyc + 1;
      end
      if (busy && cyc >= dpin_from) chk("dp_value_in_hold", 128'(dp_value_in), 128'(cur_x));
      if (w_rd_en) begin
        chk("w_addr", 128'(w_addr), 128'(exp_addr));
        exp_addr++;
        fetch_cyc = cyc;
      end
      if (out_valid && !ov_prev) begin
        chk("fetch_to_valid", 128'(cyc - fetch_cyc), 128'(3));
        if (check_spacing && rises > 0) chk("tile_spacing", 128'(cyc - last_rise), 128'(4));
        rises++;
        last_rise = cyc;
      end
      if (out_valid && pend) begin
        chk("stall_data", 128'(out_data), 128'(held_data));
        chk("stall_tile", 128'(out_tile), 128'(held_tile));
        chk("stall_no_fetch", 128'(w_rd_en), 128'(0));
      end
      if (out_valid && out_ready) begin
        exp_t e;
        outs++;
        if (sb.size() == 0) chk("unexpected_output", 128'(1), 128'(0));
        else begin
          e = sb.pop_front();
          chk("out_tile", 128'(out_tile), 128'(e.tile));
          chk("out_data", 128'(out_data), 128'(e.data));
        end
      end
      pend      = out_valid && !out_ready;
      held_data = out_data;
      held_tile = out_tile;
      ov_prev   = out_valid;
    end else begin
      pend    = 0;
      ov_prev = 0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    chk({tag, "_w_rd_en"}, 128'(w_rd_en), 128'(0));
    chk({tag, "_w_addr"}, 128'(w_addr), 128'(0));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_out_data"}, 128'(out_data), 128'(0));
    chk({tag, "_out_tile"}, 128'(out_tile), 128'(0));
    chk({tag, "_dp_value_in"}, 128'(dp_value_in), 128'(0));
    chk({tag, "_dp_weight"}, 128'(dp_weight), 128'(0));
  endtask

  task automatic init_layer(input vec_t v);
    outs = 0; dones = 0; accepts = 0; exp_addr = 0; rises = 0;
    cur_x = v.x; dpin_from = BIG;
    stall_tile = v.stall_tile; stall_left = v.stall_cyc;
    rand_bp = v.bp; check_spacing = v.spacing;
    for (int t = 0; t < v.exp_cnt; t++) sb.push_back('{TW'(t), exp_out(TW'(t), v.x)});
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic run_layer(input vec_t v);
    int budget;
    bit swapped, poked;
    init_layer(v);
    in_data = v.x; in_valid = 1'b1; num_tiles = v.num; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; num_tiles = (TW+1)'($urandom);
    @(negedge clk);
    chk("busy_after_start", 128'(busy), 128'(1));
    budget = 0; swapped = 0; poked = 0;
    while (dones == 0 && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
      start = 1'b0;
      if (!swapped && accepts > 0) begin
        in_data = ~v.x;
        swapped = 1;
      end else if (swapped && !poked) begin
        start = 1'b1;
        num_tiles = (TW+1)'(7);
        poked = 1;
      end
    end
    start = 1'b0;
    chk("layer_timeout", 128'(budget >= 3000), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("done_pulses", 128'(dones), 128'(1));
    chk("output_count", 128'(outs), 128'(v.exp_cnt));
    chk("input_accepts", 128'(accepts), 128'(v.exp_acc));
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    chk("busy_after_done", 128'(busy), 128'(0));
    sb.delete();
  endtask

  initial begin
    bit found;
    vec_t rv;
    vecs[0] = '{5'd3,  64'h0123_4567_89AB_CDEF,  3, 1, -1, 0, 1'b0, 1'b1};
    vecs[1] = '{5'd3,  64'hFEDC_BA98_7654_3210,  3, 1,  1, 5, 1'b0, 1'b0};
    vecs[2] = '{5'd0,  64'h1111_2222_3333_4444,  0, 0, -1, 0, 1'b0, 1'b0};
    vecs[3] = '{5'd20, 64'hA5A5_5A5A_C3C3_3C3C, 16, 1, -1, 0, 1'b0, 1'b1};
    vecs[4] = '{5'd16, 64'h0F1E_2D3C_4B5A_6978, 16, 1,  9, 3, 1'b1, 1'b0};
    vecs[5] = '{5'd1,  64'hDEAD_BEEF_CAFE_F00D,  1, 1, -1, 0, 1'b0, 1'b0};
    vecs[6] = '{5'd5,  64'h7777_0000_FFFF_1234,  5, 1, -1, 0, 1'b1, 1'b0};

    rst_n = 1'b1; start = 1'b0; num_tiles = '0; in_valid = 1'b0; in_data = '0;
    #3 rst_n = 1'b0;
    #1 check_zero("por");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-tile layer: done exactly one cycle after start is sampled.
    dones = 0; accepts = 0; outs = 0;
    num_tiles = '0; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("zero_done_early", 128'(done), 128'(0));
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("zero_done", 128'(done), 128'(1));
    chk("zero_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("zero_done_drop", 128'(done), 128'(0));
    chk("zero_busy_drop", 128'(busy), 128'(0));
    chk("zero_no_accept", 128'(accepts), 128'(0));
    chk("zero_no_output", 128'(outs), 128'(0));
    in_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_layer(vecs[i]);

    // Reset while tile 2 of 4 is being offered.
    rv = '{5'd4, 64'h1357_9BDF_2468_ACE0, 2, 1, 2, BIG, 1'b0, 1'b0};
    init_layer(rv);
    in_data = rv.x; in_valid = 1'b1; num_tiles = rv.num; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_tile == TW'(2)) found = 1;
    end
    chk("reach_emit_tile2", 128'(found), 128'(1));
    #1 rst_n = 1'b0;
    #1 check_zero("midrst");
    chk("midrst_outputs_seen", 128'(outs), 128'(2));
    chk("midrst_scoreboard", 128'(sb.size()), 128'(0));
    stall_left = 0; in_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", 128'(dones), 128'(0));
    chk("midrst_idle", 128'(busy), 128'(0));
    rv = '{5'd1, 64'h0BAD_F00D_1234_5678, 1, 1, -1, 0, 1'b0, 1'b0};
    run_layer(rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_layer_sequencer.md
BNN_LAYER_SEQUENCER -- requirements
Module: bnn_layer_sequencer

Interface
REQ-001 SHALL have parameter IN_DIM, default 16: input vector elements per pass.
REQ-002 SHALL have parameter OUT_DIM, default 8: output neurons per datapath pass (one tile).
REQ-003 SHALL have parameter BIT_CNT, default 4: bits per input and output element.
REQ-004 SHALL have parameter MAX_TILES, default 16: maximum tiles per layer; derived TW = $clog2(MAX_TILES).
REQ-005 SHALL have port clk  input  1  sole clock; one clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  layer-start pulse.
REQ-008 SHALL have port num_tiles  input  TW+1  tiles in this layer, sampled with start.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last tile handshake.
REQ-011 SHALL have ports in_valid input 1, in_ready output 1 and in_data input IN_DIM*BIT_CNT: input vector handshake.
REQ-012 SHALL have ports w_rd_en output 1, w_addr output TW and w_rdata input OUT_DIM*IN_DIM: weight memory read port with one-cycle latency.
REQ-013 SHALL have ports dp_value_in output IN_DIM*BIT_CNT, dp_weight output OUT_DIM*IN_DIM and dp_value_out input OUT_DIM*BIT_CNT: combinational binarized datapath.
REQ-014 SHALL have ports out_valid output 1, out_ready input 1, out_data output OUT_DIM*BIT_CNT and out_tile output TW: result handshake.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, FETCH, LATCH, EVAL, EMIT and DONE.
REQ-016 IDLE: start=1 SHALL latch num_tiles, clear the tile counter, raise busy and go to LOAD; start outside IDLE SHALL be ignored.
REQ-017 num_tiles=0 SHALL go IDLE->DONE, with no input or output handshakes; num_tiles>MAX_TILES SHALL be clamped to MAX_TILES.
REQ-018 LOAD: in_ready=1; in_valid&in_ready SHALL register in_data into dp_value_in and go to FETCH; in_ready=0 in every other state.
REQ-019 FETCH: w_rd_en=1 for exactly one cycle with w_addr=tile counter; then LATCH.
REQ-020 LATCH: w_rdata SHALL be registered into dp_weight; then EVAL.
REQ-021 EVAL: dp_value_out SHALL be registered into out_data and tile counter into out_tile; then EMIT.
REQ-022 EMIT: out_valid=1, with out_data/out_tile stable until out_valid&out_ready.
REQ-023 EMIT handshake, tile counter < latched count-1: increment counter and go to FETCH (input vector reused); tile counter = count-1: go to DONE.
REQ-024 DONE SHALL assert done for one cycle, deassert busy at its end and return to IDLE.
REQ-025 Latency: out_valid SHALL rise exactly 3 cycles after entering FETCH; each tile takes 4 cycles with out_ready held high.
REQ-026 dp_value_in SHALL hold constant for the whole layer; dp_weight SHALL change only in LATCH.
REQ-027 The tile counter SHALL never wrap; w_addr SHALL always be < latched count.

Reset
REQ-028 rst_n low SHALL, asynchronously, force IDLE and zero busy, done, in_ready, w_rd_en, w_addr, out_valid, out_data, out_tile, dp_value_in, dp_weight and the tile counter.
REQ-029 Reset mid-layer SHALL abandon the layer with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-030 Package bnn_ctrl_pkg SHALL hold the FSM state enum typedef and shared default dimension localparams (IN_DIM, OUT_DIM, BIT_CNT, MAX_TILES).
REQ-031 The block SHALL contain no sub-module: the datapath and weight memory SHALL stay external and be connected through the dp_* and w_* ports.

Verification
REQ-032 Reset then start, num_tiles=3, out_ready=1: out_tile 0,1,2 each 4 cycles apart, w_addr 0,1,2, then a single done pulse.
REQ-033 out_ready=0 for 5 cycles in EMIT of tile 1: out_valid held, out_data/out_tile unchanged, no w_rd_en until the handshake.
REQ-034 start with num_tiles=0: done 1 cycle later, in_ready never asserted, out_valid never asserted.
REQ-035 num_tiles=20, MAX_TILES=16: exactly 16 outputs with out_tile 0..15, then done.
REQ-036 rst_n low during EMIT of tile 2 of 4: all outputs 0 immediately, no done; a new start with num_tiles=1 completes normally.
REQ-037 start pulsed while busy, and in_valid held high outside LOAD: no effect, with a single input acceptance per layer.
